// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if: tail-key load and round-key output handshake bundle
interface aes_inv_key_schedule_if #(parameter int NK = 8);
  logic             in_valid;
  logic             in_ready;
  logic [32*NK-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_key;
  logic [3:0]       out_round;
  logic             out_last;
  logic             busy;
  modport master (output in_valid, in_key, out_ready, input in_ready, out_valid, out_key, out_round, out_last, busy);
  modport slave  (input in_valid, in_key, out_ready, output in_ready, out_valid, out_key, out_round, out_last, busy);
endinterface

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: walks the AES expanded key backwards, one word per cycle, emitting round keys NR..0
module aes_inv_key_schedule #(parameter int NK = 8) (
  input logic                   clk,
  input logic                   rst_n,
  aes_inv_key_schedule_if.slave bus
);
  localparam int NR = NK + 6;
  localparam int I0 = 4 * (NR + 1) - 1;
  localparam logic [5:0] J0 = 6'(I0 + 1 - NK);
  localparam logic [2:0] PM0 = 3'(I0 % NK);
  localparam logic [3:0] PD0 = 4'(I0 / NK);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;
  state_t       state_q, state_d;
  logic [31:0]  w_q [NK];
  logic [31:0]  w_d [NK];
  logic [5:0]   j_q, j_d, off;
  logic [3:0]   r_q, r_d, pd_q, pd_d, out_round_q, out_round_d;
  logic [2:0]   pm_q, pm_d;
  logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [127:0] out_key_q, out_key_d;
  logic [31:0]  sin, sout, g, win;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1: return 8'h01;
      4'd2: return 8'h02;
      4'd3: return 8'h04;
      4'd4: return 8'h08;
      4'd5: return 8'h10;
      4'd6: return 8'h20;
      4'd7: return 8'h40;
      4'd8: return 8'h80;
      4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // g() of the word under the top; RotWord and plain SubWord share one 4-byte S-box
  always_comb begin
    sin = pm_q == 3'd0 ? {w_q[NK-2][23:0], w_q[NK-2][31:24]} : w_q[NK-2];
    sout = {sbox(sin[31:24]), sbox(sin[23:16]), sbox(sin[15:8]), sbox(sin[7:0])};
    g = pm_q == 3'd0 ? sout ^ {rcon(pd_q), 24'h0} : (NK == 8 && pm_q == 3'd4) ? sout : w_q[NK-2];
    win = w_q[NK-1] ^ g;
  end

  // next state: load tail, step the window down until it covers round r, then hold the key until accepted
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    j_d = j_q;
    r_d = r_q;
    pm_d = pm_q;
    pd_d = pd_q;
    out_valid_d = out_valid_q;
    out_key_d = out_key_q;
    out_round_d = out_round_q;
    out_last_d = out_last_q;
    off = {r_q, 2'b00} - j_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        for (int k = 0; k < NK; k++) w_d[k] = bus.in_key[32*(NK-k)-1 -: 32];
        j_d = J0;
        r_d = 4'(NR);
        pm_d = PM0;
        pd_d = PD0;
        state_d = RUN;
      end
      RUN: if (j_q <= {r_q, 2'b00}) begin
        for (int k = 0; k <= NK - 4; k++)
          if (off == 6'(k)) out_key_d = {w_q[k], w_q[k+1], w_q[k+2], w_q[k+3]};
        out_valid_d = 1'b1;
        out_round_d = r_q;
        out_last_d = r_q == 4'd0;
        state_d = EMIT;
      end else begin
        w_d[0] = win;
        for (int k = 1; k < NK; k++) w_d[k] = w_q[k-1];
        j_d = j_q - 6'd1;
        pm_d = pm_q == 3'd0 ? 3'(NK - 1) : pm_q - 3'd1;
        pd_d = pm_q == 3'd0 ? pd_q - 4'd1 : pd_q;
      end
      EMIT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        r_d = r_q == 4'd0 ? r_q : r_q - 4'd1;
        state_d = r_q == 4'd0 ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      w_q <= '{default: '0};
      j_q <= '0;
      r_q <= '0;
      pm_q <= '0;
      pd_q <= '0;
      out_valid_q <= 1'b0;
      out_key_q <= '0;
      out_round_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      j_q <= j_d;
      r_q <= r_d;
      pm_q <= pm_d;
      pd_q <= pd_d;
      out_valid_q <= out_valid_d;
      out_key_q <= out_key_d;
      out_round_q <= out_round_d;
      out_last_q <= out_last_d;
    end

  assign bus.in_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.out_key = out_key_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last = out_last_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: scoreboard bench for NK=4/6/8 against a forward key-expansion model
module tb_aes_inv_key_schedule;
  typedef struct {logic [127:0] key; logic [3:0] rnd; logic last;} exp_t;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   iv, ordy, ovld, olast, irdy, bsy;
  logic [255:0] ik;
  logic [127:0] okey [3];
  logic [3:0]   oround [3];
  int           total = 0, bad = 0, act = 0;
  exp_t         sb [$];
  exp_t         e;
  logic [127:0] klog [$];
  logic [7:0]   sbt [256];
  logic [31:0]  ws [60];
  logic         held = 1'b0;
  logic [127:0] hkey;
  logic [3:0]   hrnd;

  aes_inv_key_schedule_if #(.NK(4)) b4 ();
  aes_inv_key_schedule_if #(.NK(6)) b6 ();
  aes_inv_key_schedule_if #(.NK(8)) b8 ();
  aes_inv_key_schedule #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  aes_inv_key_schedule #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));
  aes_inv_key_schedule #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  assign b4.in_valid = iv[0];
  assign b6.in_valid = iv[1];
  assign b8.in_valid = iv[2];
  assign b4.in_key = ik[255:128];
  assign b6.in_key = ik[255:64];
  assign b8.in_key = ik;
  assign b4.out_ready = ordy[0];
  assign b6.out_ready = ordy[1];
  assign b8.out_ready = ordy[2];
  assign ovld = {b8.out_valid, b6.out_valid, b4.out_valid};
  assign olast = {b8.out_last, b6.out_last, b4.out_last};
  assign irdy = {b8.in_ready, b6.in_ready, b4.in_ready};
  assign bsy = {b8.busy, b6.busy, b4.busy};
  assign okey[0] = b4.out_key;
  assign okey[1] = b6.out_key;
  assign okey[2] = b8.out_key;
  assign oround[0] = b4.out_round;
  assign oround[1] = b6.out_round;
  assign oround[2] = b8.out_round;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, 8'(x));
      sbt[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input int nk, input logic [255:0] ck);
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) ws[i] = ck[255 - 32 * i -: 32];
      else begin
        t = ws[i - 1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) t = subw(t);
        ws[i] = ws[i - nk] ^ t;
      end
    end
  endtask

  function automatic logic [255:0] tail_of(input int nk);
    logic [255:0] t;
    t = '0;
    for (int k = 0; k < nk; k++) t[255 - 32 * k -: 32] = ws[4 * (nk + 7) - nk + k];
    return t;
  endfunction

  task automatic load(input int s, input int nk, input logic [255:0] ck, input logic [255:0] tail);
    expand(nk, ck);
    for (int r = nk + 6; r >= 0; r--)
      sb.push_back(exp_t'{{ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]}, 4'(r), r == 0});
    klog.delete();
    act = s;
    @(negedge clk);
    ik = tail;
    iv[s] = 1'b1;
    @(posedge clk);
    #1 iv[s] = 1'b0;
    check("busy_after_load", bsy[s], 1);
    check("ready_after_load", irdy[s], 0);
  endtask

  task automatic drain(input int s, input int nk, input bit thr);
    int cnt;
    bit fin;
    cnt = 0;
    fin = 1'b0;
    while (!fin && cnt < 3000) begin
      ordy[s] = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (thr && $urandom_range(0, 5) == 0) begin
        ik = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        iv[s] = 1'b1;
      end
      @(negedge clk);
      fin = ovld[s] && ordy[s] && olast[s];
      @(posedge clk);
      #1 cnt++;
      iv[s] = 1'b0;
      if (cnt == 1) check("first_valid", ovld[s], 1);
    end
    check("finished", fin, 1);
    if (!thr) check("edges", cnt, 4 * (nk + 7) - nk + 2 * (nk + 7));
    check("idle_ready", irdy[s], 1);
    check("idle_busy", bsy[s], 0);
    check("sb_empty", sb.size(), 0);
    ordy[s] = 1'b1;
  endtask

  task automatic check_reset(input int s);
    check("rst_valid", ovld[s], 0);
    check("rst_key", okey[s], 0);
    check("rst_round", oround[s], 0);
    check("rst_last", olast[s], 0);
    check("rst_ready", irdy[s], 1);
    check("rst_busy", bsy[s], 0);
  endtask

  // scoreboard: pop on each handshake, and require stalled outputs to hold still
  always @(negedge clk) begin
    if (ovld[act]) begin
      if (held) begin
        check("stall_key", okey[act], hkey);
        check("stall_round", oround[act], hrnd);
      end
      held = !ordy[act];
      hkey = okey[act];
      hrnd = oround[act];
      if (ordy[act]) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          klog.push_back(okey[act]);
          check("key", okey[act], e.key);
          check("round", oround[act], e.rnd);
          check("last", olast[act], e.last);
        end
      end
    end else held = 1'b0;
  end

  initial begin
    logic [255:0] ck;
    bit hit;
    build_sbox();
    rst_n = 1'b0;
    iv = '0;
    ordy = 3'b111;
    ik = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) check_reset(s);
    rst_n = 1'b1;
    load(0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0});
    drain(0, 4, 0);
    check("a1_rk10", klog[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a1_rk9", klog[1], 128'hac7766f319fadc2128d12941575c006e);
    check("a1_rk0", klog[$], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    load(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, {128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h0});
    drain(0, 4, 0);
    check("c1_rk0", klog[$], 128'h000102030405060708090a0b0c0d0e0f);
    load(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
         {128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36});
    drain(2, 8, 0);
    check("c3_rk14", klog[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("c3_rk13", klog[1], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
    check("c3_rk0", klog[$], 128'h000102030405060708090a0b0c0d0e0f);
    check("c3_count", klog.size(), 15);
    ck = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0};
    expand(6, ck);
    load(1, 6, ck, tail_of(6));
    drain(1, 6, 0);
    check("nk6_count", klog.size(), 13);
    ck = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(8, ck);
    load(2, 8, ck, tail_of(8));
    drain(2, 8, 1);
    check("thr_count", klog.size(), 15);
    ck = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(8, ck);
    load(2, 8, ck, tail_of(8));
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(negedge clk);
      hit = ovld[2] && oround[2] == 4'd8;
    end
    check("abort_reached", hit, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset(2);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load(2, 8, ck, tail_of(8));
    drain(2, 8, 0);
    check("reload_count", klog.size(), 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
